gray_pntr_ctrl: RTL and testbench

- Single-clock-domain pointer controller for one side of a dual-clock FIFO (write or read side, chosen by parameter).
- Keeps the local binary/Gray pointer pair and synchronises the remote Gray pointer from the other domain.
- Converts the synchronised remote pointer to binary over its full width, including the MSB.
- Produces registered full/empty, almost flags, a fill count and an overflow/underflow error pulse.
- One instance per clock domain; replaces ad-hoc pointer logic in the FIFO top level.

---
 rtl/gray_pntr_ctrl.sv | 125 ++++++++++++
 tb/tb_gray_pntr_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_pntr_ctrl.sv
// One-side pointer controller for a dual-clock FIFO.
// Local bin/Gray pointer, remote sync, flags, fill count, error pulse.
//
// Ports:
//   clk_i           local-domain clock
//   srst_n_i        synchronous reset, active low
//   inc_i           increment request (wrreq or rdreq)
//   rmt_pntr_gray_i Gray pointer from the other domain (async)
//   pntr_addr_o     RAM address (low AWIDTH bits of local pointer)
//   pntr_gray_o     registered local Gray pointer for the crossing
//   flag_o          full (SIDE=0) or empty (SIDE=1)
//   almost_flag_o   almost full (SIDE=0) or almost empty (SIDE=1)
//   usedw_o         words stored as seen from this domain
//   err_o           one-cycle pulse on a rejected increment
module gray_pntr_ctrl #(
  parameter int AWIDTH      = 4,
  parameter int SIDE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_LVL  = 2
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              inc_i,
  input  logic [AWIDTH:0]   rmt_pntr_gray_i,
  output logic [AWIDTH-1:0] pntr_addr_o,
  output logic [AWIDTH:0]   pntr_gray_o,
  output logic              flag_o,
  output logic              almost_flag_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              err_o
);

  localparam int AWVAL = AWIDTH + 1;
  localparam int DEPTH = 1 << AWIDTH;

  // Threshold may go negative when ALMOST_LVL > DEPTH,
  // so the almost-full compare is done in signed int.
  localparam int ALMOST_TH = DEPTH - ALMOST_LVL;

  // Full: remote pointer with its two MSBs inverted.
  // Shifting keeps this valid for AWIDTH=1 too.
  localparam logic [AWIDTH:0] FULL_MASK =
    AWVAL'(3) << (AWIDTH - 1);

  localparam logic FLAG_RST = (SIDE != 0);
  localparam logic ALMOST_RST =
    (SIDE != 0) ? 1'b1 : (ALMOST_LVL >= DEPTH);

  logic [AWIDTH:0] sync_q [SYNC_STAGES];
  logic [AWIDTH:0] rmt_sync;
  logic [AWIDTH:0] rmt_bin;

  logic [AWIDTH:0] bin_q;
  logic [AWIDTH:0] bin_nxt;
  logic [AWIDTH:0] gray_nxt;
  logic [AWIDTH:0] usedw_nxt;
  logic            inc_ok;
  logic            flag_nxt;
  logic            almost_nxt;

  // Remote pointer synchroniser
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rmt_pntr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rmt_sync = sync_q[SYNC_STAGES-1];

  // Full-width Gray-to-binary, MSB included
  always_comb begin
    rmt_bin = '0;
    for (int k = 0; k <= AWIDTH; k++) begin
      rmt_bin[k] = ^(rmt_sync >> k);
    end
  end

  assign inc_ok = inc_i & ~flag_o;

  // Next-state pointer, flags and fill count
  always_comb begin
    bin_nxt    = bin_q + AWVAL'(inc_ok);
    gray_nxt   = bin_nxt ^ (bin_nxt >> 1);
    usedw_nxt  = '0;
    flag_nxt   = 1'b0;
    almost_nxt = 1'b0;
    if (SIDE == 0) begin
      usedw_nxt  = bin_nxt - rmt_bin;
      flag_nxt   = (gray_nxt == (rmt_sync ^ FULL_MASK));
      almost_nxt = (int'(usedw_nxt) >= ALMOST_TH);
    end else begin
      usedw_nxt  = rmt_bin - bin_nxt;
      flag_nxt   = (gray_nxt == rmt_sync);
      almost_nxt = (int'(usedw_nxt) <= ALMOST_LVL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      bin_q         <= '0;
      pntr_gray_o   <= '0;
      usedw_o       <= '0;
      flag_o        <= FLAG_RST;
      almost_flag_o <= ALMOST_RST;
      err_o         <= 1'b0;
    end else begin
      bin_q         <= bin_nxt;
      pntr_gray_o   <= gray_nxt;
      usedw_o       <= usedw_nxt;
      flag_o        <= flag_nxt;
      almost_flag_o <= almost_nxt;
      err_o         <= inc_i & flag_o;
    end
  end

  assign pntr_addr_o = bin_q[AWIDTH-1:0];

endmodule

// File: tb/tb_gray_pntr_ctrl.sv
// Directed bench for gray_pntr_ctrl.
// Write side, read side and a 1-bit / 3-stage boundary instance.
module tb_gray_pntr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // write side, AWIDTH=4, 2 sync stages
  logic       wr_srst_n, wr_inc;
  logic [4:0] wr_rmt, wr_gray, wr_usedw;
  logic [3:0] wr_addr;
  logic       wr_flag, wr_almost, wr_err;

  // read side, AWIDTH=4, 2 sync stages
  logic       rd_srst_n, rd_inc;
  logic [4:0] rd_rmt, rd_gray, rd_usedw;
  logic [3:0] rd_addr;
  logic       rd_flag, rd_almost, rd_err;

  // write side, AWIDTH=1, 3 sync stages
  logic       s3_srst_n, s3_inc;
  logic [1:0] s3_rmt, s3_gray, s3_usedw;
  logic [0:0] s3_addr;
  logic       s3_flag, s3_almost, s3_err;

  gray_pntr_ctrl #(
    .AWIDTH(4), .SIDE(0), .SYNC_STAGES(2), .ALMOST_LVL(2)
  ) u_wr (
    .clk_i(clk), .srst_n_i(wr_srst_n), .inc_i(wr_inc),
    .rmt_pntr_gray_i(wr_rmt), .pntr_addr_o(wr_addr),
    .pntr_gray_o(wr_gray), .flag_o(wr_flag),
    .almost_flag_o(wr_almost), .usedw_o(wr_usedw),
    .err_o(wr_err)
  );

  gray_pntr_ctrl #(
    .AWIDTH(4), .SIDE(1), .SYNC_STAGES(2), .ALMOST_LVL(2)
  ) u_rd (
    .clk_i(clk), .srst_n_i(rd_srst_n), .inc_i(rd_inc),
    .rmt_pntr_gray_i(rd_rmt), .pntr_addr_o(rd_addr),
    .pntr_gray_o(rd_gray), .flag_o(rd_flag),
    .almost_flag_o(rd_almost), .usedw_o(rd_usedw),
    .err_o(rd_err)
  );

  gray_pntr_ctrl #(
    .AWIDTH(1), .SIDE(0), .SYNC_STAGES(3), .ALMOST_LVL(2)
  ) u_s3 (
    .clk_i(clk), .srst_n_i(s3_srst_n), .inc_i(s3_inc),
    .rmt_pntr_gray_i(s3_rmt), .pntr_addr_o(s3_addr),
    .pntr_gray_o(s3_gray), .flag_o(s3_flag),
    .almost_flag_o(s3_almost), .usedw_o(s3_usedw),
    .err_o(s3_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int g(input int b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    wr_srst_n = 0; wr_inc = 0; wr_rmt = '0;
    rd_srst_n = 0; rd_inc = 0; rd_rmt = '0;
    s3_srst_n = 0; s3_inc = 0; s3_rmt = '0;
    tick(2);

    check("wr_rst_flag",   wr_flag,   0);
    check("wr_rst_almost", wr_almost, 0);
    check("wr_rst_usedw",  wr_usedw,  0);
    check("wr_rst_gray",   wr_gray,   0);
    check("wr_rst_err",    wr_err,    0);
    check("rd_rst_flag",   rd_flag,   1);
    check("rd_rst_almost", rd_almost, 1);
    check("rd_rst_usedw",  rd_usedw,  0);
    check("rd_rst_addr",   rd_addr,   0);
    check("s3_rst_flag",   s3_flag,   0);
    check("s3_rst_almost", s3_almost, 1);

    wr_srst_n = 1; rd_srst_n = 1; s3_srst_n = 1;
    tick();

    // read side: increment while empty is rejected
    check("rd_idle_flag", rd_flag, 1);
    rd_inc = 1;
    tick();
    check("rd_rej_err",  rd_err,  1);
    check("rd_rej_addr", rd_addr, 0);
    rd_inc = 0;
    tick();
    check("rd_err_clr",  rd_err,  0);
    check("rd_rej_gray", rd_gray, 0);

    // write side: fill 16 words with remote held at 0
    wr_inc = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("wr_fill_gray%0d", i), wr_gray, g(i));
      check($sformatf("wr_fill_used%0d", i), wr_usedw, i);
      check($sformatf("wr_fill_alm%0d", i), wr_almost, i >= 14);
      check($sformatf("wr_fill_full%0d", i), wr_flag, i == 16);
    end
    tick();
    check("wr_17_err",   wr_err,   1);
    check("wr_17_gray",  wr_gray,  g(16));
    check("wr_17_addr",  wr_addr,  0);
    check("wr_17_usedw", wr_usedw, 16);
    wr_inc = 0;
    wr_rmt = 5'(g(1));
    tick();
    check("wr_err_clr", wr_err, 0);
    tick();
    check("wr_full_hold", wr_flag, 1);
    tick();
    check("wr_full_rel",  wr_flag,   0);
    check("wr_rel_usedw", wr_usedw,  15);
    check("wr_rel_alm",   wr_almost, 1);

    // read side: remote at 16, drain to 15 words
    rd_rmt = 5'(g(16));
    tick(2);
    check("rd_empty_hold", rd_flag, 1);
    tick();
    check("rd_avail_flag",  rd_flag,  0);
    check("rd_avail_usedw", rd_usedw, 16);
    rd_inc = 1;
    tick(15);
    check("rd_b_addr",  rd_addr,   15);
    check("rd_b_usedw", rd_usedw,  1);
    check("rd_b_alm",   rd_almost, 1);
    check("rd_b_flag",  rd_flag,   0);

    // simultaneous local read and remote advance
    rd_inc = 0;
    rd_rmt = 5'(g(17));
    tick(2);
    rd_inc = 1;
    tick();
    check("rd_sim_usedw", rd_usedw, 1);
    check("rd_sim_flag",  rd_flag,  0);
    check("rd_sim_gray",  rd_gray,  g(16));
    rd_inc = 0;

    // remote at 30 (Gray MSB set), drain to empty at 30
    rd_rmt = 5'(g(30));
    tick(3);
    check("rd_c_usedw", rd_usedw, 14);
    rd_inc = 1;
    tick(14);
    check("rd_c_empty", rd_flag,  1);
    check("rd_c_addr",  rd_addr,  14);
    check("rd_c_used0", rd_usedw, 0);

    // remote wraps past 31 to 2
    rd_inc = 0;
    rd_rmt = 5'(g(2));
    tick(3);
    check("rd_wrap_usedw", rd_usedw,  4);
    check("rd_wrap_flag",  rd_flag,   0);
    check("rd_wrap_alm",   rd_almost, 0);
    rd_inc = 1;
    tick(4);
    check("rd_wrap_gray",  rd_gray,  g(2));
    check("rd_wrap_addr",  rd_addr,  2);
    check("rd_wrap_used0", rd_usedw, 0);
    check("rd_wrap_empty", rd_flag,  1);
    rd_inc = 0;

    // write side: reset mid-burst with pointer at 9
    wr_srst_n = 0;
    wr_rmt    = '0;
    tick();
    wr_srst_n = 1;
    wr_inc    = 1;
    wr_rmt    = 5'(g(3));
    tick(9);
    check("wr_b_addr",  wr_addr,  9);
    check("wr_b_usedw", wr_usedw, 6);
    wr_srst_n = 0;
    tick();
    check("wr_mr_addr",   wr_addr,   0);
    check("wr_mr_gray",   wr_gray,   0);
    check("wr_mr_usedw",  wr_usedw,  0);
    check("wr_mr_flag",   wr_flag,   0);
    check("wr_mr_almost", wr_almost, 0);
    check("wr_mr_err",    wr_err,    0);
    wr_srst_n = 1;
    wr_inc    = 0;
    tick();
    check("wr_sync_clr1", wr_usedw, 0);
    tick();
    check("wr_sync_clr2", wr_usedw, 0);
    tick();
    check("wr_sync_arr",  wr_usedw, 29);

    // AWIDTH=1, 3 sync stages
    s3_inc = 1;
    tick();
    check("s3_1_gray",  s3_gray,  1);
    check("s3_1_usedw", s3_usedw, 1);
    check("s3_1_flag",  s3_flag,  0);
    tick();
    check("s3_2_gray",  s3_gray,  3);
    check("s3_2_usedw", s3_usedw, 2);
    check("s3_2_flag",  s3_flag,  1);
    tick();
    check("s3_rej_err",  s3_err,  1);
    check("s3_rej_gray", s3_gray, 3);
    s3_inc = 0;
    s3_rmt = 2'(g(1));
    tick(3);
    check("s3_full_hold", s3_flag, 1);
    tick();
    check("s3_full_rel",  s3_flag,  0);
    check("s3_rel_usedw", s3_usedw, 1);
    check("s3_rel_addr",  s3_addr,  0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
